// File: rtl/buf_reader.sv
// Streams num_rows consecutive register-file rows (wrapping at MEM_DEPTH) into a
// 2-entry output FIFO with valid/ready handshake. Optional BUF_READER_ROW_IDX_EN adds row_idx_o.
module buf_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_LEN    = 16,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [3:0]                     base_addr_i,
  input  logic [4:0]                     num_rows_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           rd_en_o,
  output logic [3:0]                     rd_addr_o,
  input  logic [DATA_WIDTH*MEM_LEN-1:0]  rd_data_i,
  output logic                           row_valid_o,
  input  logic                           row_ready_i,
  output logic [DATA_WIDTH*MEM_LEN-1:0]  row_data_o,
  output logic                           row_last_o
`ifdef BUF_READER_ROW_IDX_EN
  ,
  output logic [3:0]                     row_idx_o
`endif
);

  localparam int unsigned W      = DATA_WIDTH * MEM_LEN;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_issued;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [ADDR_W-1:0]   r_last_addr;
  logic                r_cap;
  logic                r_cap_last;
  logic [W-1:0]        r_data [2];
  logic                r_last [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                w_rd_en;
  logic                w_pop;
  logic                w_room;
  logic                w_is_last;
  logic [2:0]          w_load;
  logic [ADDR_W-1:0]   w_addr_inc;
`ifdef BUF_READER_ROW_IDX_EN
  logic [3:0]          r_cap_idx;
  logic [3:0]          r_idx [2];
`endif

  // Issue only if the row still fits once it lands, counting this cycle's pop.
  assign w_pop      = (r_count != 2'd0) && row_ready_i;
  assign w_load     = 3'(r_count) + 3'(r_cap) - 3'(w_pop);
  assign w_room     = (w_load < 3'd2);
  assign w_is_last  = (r_issued == r_num - CNT_W'(1));
  assign w_addr_inc = (r_next_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : r_next_addr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = (num_rows_i != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        if (w_room) begin
          w_rd_en = 1'b1;
          if (w_is_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_count == 2'd0) && !r_cap) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read sequencing and in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num       <= '0;
      r_issued    <= '0;
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_cap       <= 1'b0;
      r_cap_last  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start_i && (num_rows_i != '0)) begin
        r_num       <= num_rows_i;
        r_issued    <= '0;
        r_next_addr <= base_addr_i;
      end else if (w_rd_en) begin
        r_issued    <= r_issued + CNT_W'(1);
        r_next_addr <= w_addr_inc;
        r_last_addr <= r_next_addr;
      end
      r_cap      <= w_rd_en;
      r_cap_last <= w_rd_en && w_is_last;
    end
  end

`ifdef BUF_READER_ROW_IDX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cap_idx <= '0;
    else     r_cap_idx <= r_issued[3:0];
  end
`endif

  // Two-entry output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
`ifdef BUF_READER_ROW_IDX_EN
        r_idx[i]  <= '0;
`endif
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_cap) begin
        r_data[r_wr_ptr] <= rd_data_i;
        r_last[r_wr_ptr] <= r_cap_last;
`ifdef BUF_READER_ROW_IDX_EN
        r_idx[r_wr_ptr]  <= r_cap_idx;
`endif
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= 2'(r_count + 2'(r_cap) - 2'(w_pop));
    end
  end

  assign busy_o      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done_o      = (r_state == S_DONE);
  assign rd_en_o     = w_rd_en;
  assign rd_addr_o   = w_rd_en ? r_next_addr : r_last_addr;
  assign row_valid_o = (r_count != 2'd0);
  assign row_data_o  = r_data[r_rd_ptr];
  assign row_last_o  = row_valid_o && r_last[r_rd_ptr];
`ifdef BUF_READER_ROW_IDX_EN
  assign row_idx_o   = row_valid_o ? r_idx[r_rd_ptr] : 4'd0;
`endif

endmodule

// File: tb/tb_buf_reader.sv
// Bench for buf_reader: table of transfer scenarios, randomized transfers against a
// queue-based row model, and a mid-transfer reset sequence.
`timescale 1ns/1ps
module tb_buf_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned ML = 16;
  localparam int unsigned W  = DW * ML;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [3:0]    base_addr_i;
  logic [4:0]    num_rows_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [3:0]    rd_addr_o;
  logic [W-1:0]  rd_data_i;
  logic          row_valid_o;
  logic          row_ready_i;
  logic [W-1:0]  row_data_o;
  logic          row_last_o;
`ifdef BUF_READER_ROW_IDX_EN
  logic [3:0]    row_idx_o;
`endif

  buf_reader #(.DATA_WIDTH(DW), .MEM_LEN(ML), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_rows_i(num_rows_i), .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .row_valid_o(row_valid_o),
    .row_ready_i(row_ready_i), .row_data_o(row_data_o), .row_last_o(row_last_o)
`ifdef BUF_READER_ROW_IDX_EN
    , .row_idx_o(row_idx_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   idx;
  } row_t;

  typedef struct {
    logic [3:0] base;
    int         num;
    int         mode;       // 0: ready=1, 1: toggling, 2: random
    int         restart_at; // cycle of an extra start pulse, -1 none
    int         exp_first;  // first row_valid cycle, -1 never
    int         exp_done;   // done_o cycle, -1 unchecked
  } vec_t;

  logic [W-1:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;

  // Register file model: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    logic [W-1:0] g;
    for (int j = 0; j < int'(W / 32); j++) g[j*32 +: 32] = $urandom;
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    else         rd_data_i <= g;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, W'(busy_o), '0);
    chk({tag, "_done"}, W'(done_o), '0);
    chk({tag, "_rd_en"}, W'(rd_en_o), '0);
    chk({tag, "_rd_addr"}, W'(rd_addr_o), '0);
    chk({tag, "_valid"}, W'(row_valid_o), '0);
    chk({tag, "_last"}, W'(row_last_o), '0);
    chk({tag, "_data"}, row_data_o, '0);
  endtask

  // Runs one transfer from an idle DUT; entered and left at posedge+1.
  task automatic run_xfer(input vec_t v);
    row_t         exp_q[$];
    logic [3:0]   addr_q[$];
    int           c = 0, first = -1, done_at = -1, busy_n = 0;
    logic         stall = 1'b0;
    logic [W-1:0] stall_data = '0;
    for (int k = 0; k < v.num; k++) begin
      logic [3:0] a;
      row_t r;
      a = 4'((int'(v.base) + k) % 16);
      addr_q.push_back(a);
      r.data = mem[a]; r.last = (k == v.num - 1); r.idx = 4'(k);
      exp_q.push_back(r);
    end
    start_i = 1'b1; base_addr_i = v.base; num_rows_i = 5'(v.num);
    row_ready_i = rdy(v.mode, 0);
    while (done_at < 0 && c < 300) begin
      @(negedge clk);
      if (rd_en_o) begin
        if (addr_q.size() == 0) chk("extra_read", W'(rd_en_o), '0);
        else chk("rd_addr", W'(rd_addr_o), W'(addr_q.pop_front()));
      end
      if (stall) begin
        chk("stall_valid", W'(row_valid_o), W'(1));
        chk("stall_data", row_data_o, stall_data);
      end
      stall = 1'b0;
      if (row_valid_o) begin
        if (first < 0) first = c;
        if (exp_q.size() == 0) chk("extra_row", W'(row_valid_o), '0);
        else begin
          chk("row_last", W'(row_last_o), W'(exp_q[0].last));
`ifdef BUF_READER_ROW_IDX_EN
          chk("row_idx", W'(row_idx_o), W'(exp_q[0].idx));
`endif
          if (row_ready_i) chk("row_data", row_data_o, exp_q.pop_front().data);
          else begin
            stall = 1'b1; stall_data = row_data_o;
          end
        end
      end else begin
        chk("last_when_empty", W'(row_last_o), '0);
      end
      if (done_o) done_at = c;
      if (busy_o) busy_n++;
      @(posedge clk); #1;
      c++;
      start_i = (c == v.restart_at);
      if (start_i) begin
        base_addr_i = ~v.base; num_rows_i = 5'd7;
      end
      row_ready_i = rdy(v.mode, c);
    end
    start_i = 1'b0;
    chk("done_seen", W'(done_at >= 0), W'(1));
    if (v.exp_done >= 0) chk("done_cycle", W'(done_at), W'(v.exp_done));
    chk("first_valid", W'(first), W'(v.exp_first));
    chk("busy_cycles", W'(busy_n), W'((v.num > 0) ? done_at - 1 : 0));
    chk("rows_left", W'(exp_q.size()), '0);
    chk("reads_left", W'(addr_q.size()), '0);
    @(negedge clk);
    chk("done_one_cycle", W'(done_o), '0);
    chk("idle_busy", W'(busy_o), '0);
    chk("idle_valid", W'(row_valid_o), '0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < int'(W / 32); j++) mem[r][j*32 +: 32] = $urandom;
    vecs.push_back('{4'd0,  16, 0, -1,  3, 20});
    vecs.push_back('{4'd14,  4, 0, -1,  3,  8});
    vecs.push_back('{4'd3,   4, 1, -1,  3, -1});
    vecs.push_back('{4'd5,   0, 0, -1, -1,  1});
    vecs.push_back('{4'd2,   6, 0,  3,  3, 10});
    vecs.push_back('{4'd9,   1, 0, -1,  3,  5});
    vecs.push_back('{4'd15,  2, 1, -1,  3, -1});

    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0; row_ready_i = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_xfer(vecs[i]);

    for (int i = 0; i < 25; i++) begin
      vec_t v;
      v.base = 4'($urandom_range(0, 15));
      v.num  = $urandom_range(0, 16);
      v.mode = 2;
      v.restart_at = (v.num > 0 && ($urandom_range(0, 2) == 0)) ? $urandom_range(1, v.num) : -1;
      v.exp_first = (v.num > 0) ? 3 : -1;
      v.exp_done  = -1;
      run_xfer(v);
    end

    // Reset after two of eight rows have been delivered
    begin
      int got = 0;
      start_i = 1'b1; base_addr_i = 4'd4; num_rows_i = 5'd8; row_ready_i = 1'b1;
      for (int c = 0; c < 20 && got < 2; c++) begin
        @(negedge clk);
        if (row_valid_o && row_ready_i) got++;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      chk("pre_reset_rows", W'(got), W'(2));
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("post_reset_valid", W'(row_valid_o), '0);
        chk("post_reset_rd_en", W'(rd_en_o), '0);
        chk("post_reset_busy", W'(busy_o), '0);
      end
      @(posedge clk); #1;
      run_xfer('{4'd7, 5, 0, -1, 3, 9});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
